// File: rtl/volcado_memoria_debug_if.sv
// Bus between the memory dumper and its surroundings: the data memory
// debug port on one side and the TX byte stream on the other.
interface volcado_memoria_debug_if #(
  parameter int NBITS = 32
);
  logic             i_Start;
  logic [NBITS-1:0] o_DebugDireccion;
  logic [NBITS-1:0] i_DebugDato;
  logic [7:0]       o_TxDato;
  logic             o_TxValid;
  logic             i_TxReady;
  logic             o_Busy;
  logic             o_Done;

  // Dumper side
  modport master (
    input  i_Start, i_DebugDato, i_TxReady,
    output o_DebugDireccion, o_TxDato, o_TxValid, o_Busy, o_Done
  );

  // Memory / TX / control side
  modport slave (
    output i_Start, i_DebugDato, i_TxReady,
    input  o_DebugDireccion, o_TxDato, o_TxValid, o_Busy, o_Done
  );
endinterface

// File: rtl/volcado_memoria_debug.sv
// Walks every data memory cell through the debug port and streams each
// word MSB-byte-first onto an 8-bit valid/ready byte stream.
module volcado_memoria_debug #(
  parameter int NBITS  = 32,
  parameter int CELDAS = 16
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  volcado_memoria_debug_if.master bus
);
  localparam int NBYTES = NBITS / 8;
  localparam int AW     = (CELDAS > 1) ? $clog2(CELDAS) : 1;
  localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(CELDAS - 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(NBYTES - 1);

  typedef enum logic [2:0] {IDLE, SET_ADDR, CAPTURE, SEND, NEXT, DONE} state_t;

  state_t           state;
  logic [AW-1:0]    addr;
  logic [BW-1:0]    bcnt;
  logic [NBITS-1:0] shift;
  logic [NBITS-1:0] dir;
  logic             tx_valid;
  logic             busy;
  logic             done;

  // The outgoing byte is always the top of the captured word, so it is
  // frozen whenever the shift register is not advancing.
  assign bus.o_DebugDireccion = dir;
  assign bus.o_TxDato         = shift[NBITS-1 -: 8];
  assign bus.o_TxValid        = tx_valid;
  assign bus.o_Busy           = busy;
  assign bus.o_Done           = done;

  // Dump sequencer: state plus all registered outputs
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= IDLE;
      addr     <= '0;
      bcnt     <= '0;
      shift    <= '0;
      dir      <= '0;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_Start) begin
            addr  <= '0;
            dir   <= '0;
            busy  <= 1'b1;
            state <= SET_ADDR;
          end
        end
        // Address already presented on entry; give the debug read a cycle.
        SET_ADDR: state <= CAPTURE;
        // Word is latched once here; later memory changes don't leak in.
        CAPTURE: begin
          shift    <= bus.i_DebugDato;
          bcnt     <= '0;
          tx_valid <= 1'b1;
          state    <= SEND;
        end
        SEND: begin
          if (tx_valid && bus.i_TxReady) begin
            shift <= shift << 8;
            bcnt  <= bcnt + BW'(1);
            if (bcnt == LAST_BYTE) begin
              tx_valid <= 1'b0;
              state    <= NEXT;
            end
          end
        end
        NEXT: begin
          if (addr == LAST_ADDR) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            addr  <= addr + AW'(1);
            dir   <= NBITS'(addr + AW'(1));
            state <= SET_ADDR;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          dir   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_volcado_memoria_debug.sv
// Bench for the memory dumper: scoreboard of expected bytes built from a
// memory model, compared against the bytes the monitor saw handshaken.
module tb_volcado_memoria_debug;
  localparam int NB = 32;
  localparam int NC = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  volcado_memoria_debug_if #(.NBITS(NB)) bus ();
  volcado_memoria_debug_if #(.NBITS(NB)) bus1 ();

  volcado_memoria_debug #(.NBITS(NB), .CELDAS(NC)) dut (
    .i_clk(clk), .i_reset(rst), .bus(bus));
  volcado_memoria_debug #(.NBITS(NB), .CELDAS(1)) dut1 (
    .i_clk(clk), .i_reset(rst), .bus(bus1));

  logic [NB-1:0] mem [NC];
  assign bus.i_DebugDato  = (bus.o_DebugDireccion < NC) ? mem[bus.o_DebugDireccion[3:0]] : '0;
  assign bus1.i_DebugDato = (bus1.o_DebugDireccion == '0) ? 32'h01020304 : 32'hFFFFFFFF;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]    b;
    logic [NB-1:0] dir;
    int            c;
  } obs_t;
  obs_t obs[$];
  int stab_viol = 0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_byte = '0;
  logic [7:0] exp_q[$];
  int rd = 0;

  // Monitor: record every handshaken byte and any byte change during a stall
  always @(negedge clk) begin
    if (rst) prev_stall <= 1'b0;
    else begin
      if (prev_stall && (!bus.o_TxValid || bus.o_TxDato != prev_byte))
        stab_viol <= stab_viol + 1;
      prev_stall <= bus.o_TxValid && !bus.i_TxReady;
      prev_byte  <= bus.o_TxDato;
      if (bus.o_TxValid && bus.i_TxReady)
        obs.push_back(obs_t'{bus.o_TxDato, bus.o_DebugDireccion, cyc});
    end
  end

  task automatic push_dump();
    for (int a = 0; a < NC; a++)
      for (int k = NB/8 - 1; k >= 0; k--) exp_q.push_back(mem[a][k*8 +: 8]);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 bus.i_Start = 1'b1;
    @(posedge clk); #1 bus.i_Start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (bus.o_TxValid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", bus.o_TxValid); end
    checks++; if (bus.o_Busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", bus.o_Busy); end
    checks++; if (bus.o_Done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", bus.o_Done); end
    checks++; if (bus.o_DebugDireccion !== '0) begin errors++; $display("FAIL rst_dir got %h exp 0", bus.o_DebugDireccion); end
    checks++; if (bus.o_TxDato !== 8'h00) begin errors++; $display("FAIL rst_dato got %h exp 00", bus.o_TxDato); end
    rst = 1'b0;
  endtask

  task automatic test_ascending();
    int n, dn, bz, dcyc, first;
    for (int i = 0; i < NC; i++) mem[i] = i;
    bus.i_TxReady = 1'b1;
    first = rd;
    push_dump();
    pulse_start();
    n = 0; dn = 0; bz = 0; dcyc = 0;
    while (n < 3000 && dn == 0) begin
      @(posedge clk); #1; n++;
      if (bus.o_Done) begin dn = 1; dcyc = cyc; end
      else if (!bus.o_Busy) bz++;
    end
    checks++; if (dn == 0) begin errors++; $display("FAIL asc_timeout got no done exp done"); end
    repeat (10) begin @(posedge clk); #1; if (bus.o_Done) dn++; end
    checks++; if (dn != 1) begin errors++; $display("FAIL asc_done_count got %0d exp 1", dn); end
    checks++; if (dcyc - start_cyc != 112) begin errors++; $display("FAIL asc_done_latency got %0d exp 112", dcyc - start_cyc); end
    checks++; if (bz != 0) begin errors++; $display("FAIL asc_busy_low got %0d exp 0", bz); end
    checks++; if (first >= obs.size() || obs[first].c != start_cyc + 2) begin
      errors++; $display("FAIL asc_first_latency got %0d exp %0d", (first < obs.size()) ? obs[first].c - start_cyc : -1, 2); end
    checks++; if (bus.o_Busy !== 1'b0 || bus.o_DebugDireccion !== '0) begin
      errors++; $display("FAIL asc_idle got busy %b dir %h exp 0 0", bus.o_Busy, bus.o_DebugDireccion); end
    while (exp_q.size() > 0) begin
      logic [7:0] e; e = exp_q.pop_front(); checks++;
      if (rd >= obs.size() || obs[rd].b !== e) begin errors++;
        $display("FAIL asc_byte%0d got %h exp %h", rd - first, (rd < obs.size()) ? obs[rd].b : 8'hxx, e); end
      rd++;
    end
    checks++; if (obs.size() != rd) begin errors++; $display("FAIL asc_extra got %0d exp %0d", obs.size(), rd); end
  endtask

  task automatic test_deadbeef();
    int n, dn, base;
    mem[3] = 32'hDEADBEEF;
    base = rd;
    push_dump();
    pulse_start();
    n = 0; dn = 0;
    while (n < 3000 && dn == 0) begin @(posedge clk); #1; n++; if (bus.o_Done) dn = 1; end
    checks++; if (dn == 0) begin errors++; $display("FAIL dbf_timeout got no done exp done"); end
    checks++; if (base + 12 >= obs.size() || obs[base+12].dir !== 32'd3) begin
      errors++; $display("FAIL dbf_dir got %h exp 3", (base + 12 < obs.size()) ? obs[base+12].dir : 'x); end
    while (exp_q.size() > 0) begin
      logic [7:0] e; e = exp_q.pop_front(); checks++;
      if (rd >= obs.size() || obs[rd].b !== e) begin errors++;
        $display("FAIL dbf_byte%0d got %h exp %h", rd - base, (rd < obs.size()) ? obs[rd].b : 8'hxx, e); end
      rd++;
    end
    mem[3] = 32'd3;
  endtask

  task automatic test_backpressure();
    int n, dn, sv, base;
    sv = stab_viol;
    base = rd;
    push_dump();
    pulse_start();
    n = 0; dn = 0;
    while (n < 5000 && dn == 0) begin
      @(posedge clk); #1; n++;
      if (bus.o_Done) dn = 1;
      bus.i_TxReady = ($urandom_range(0, 99) < 30);
    end
    bus.i_TxReady = 1'b1;
    checks++; if (dn == 0) begin errors++; $display("FAIL bp_timeout got no done exp done"); end
    checks++; if (stab_viol != sv) begin errors++; $display("FAIL bp_stable got %0d exp 0 changes", stab_viol - sv); end
    checks++; if (obs.size() - base != 64) begin errors++; $display("FAIL bp_count got %0d exp 64", obs.size() - base); end
    while (exp_q.size() > 0) begin
      logic [7:0] e; e = exp_q.pop_front(); checks++;
      if (rd >= obs.size() || obs[rd].b !== e) begin errors++;
        $display("FAIL bp_byte%0d got %h exp %h", rd - base, (rd < obs.size()) ? obs[rd].b : 8'hxx, e); end
      rd++;
    end
  endtask

  task automatic test_restart_ignored();
    int n, dn, base;
    bit pulsed;
    for (int pass = 0; pass < 2; pass++) begin
      base = rd;
      push_dump();
      pulse_start();
      n = 0; dn = 0; pulsed = 0;
      while (n < 3000 && dn == 0) begin
        @(posedge clk); #1; n++;
        if (bus.o_Done) dn = 1;
        if (pass == 0 && !pulsed && obs.size() - base >= 20) begin bus.i_Start = 1'b1; pulsed = 1; end
        else bus.i_Start = 1'b0;
      end
      bus.i_Start = 1'b0;
      checks++; if (dn == 0) begin errors++; $display("FAIL rs%0d_timeout got no done exp done", pass); end
      repeat (20) begin @(posedge clk); #1; if (bus.o_Done) dn++; end
      checks++; if (dn != 1) begin errors++; $display("FAIL rs%0d_done_count got %0d exp 1", pass, dn); end
      checks++; if (obs.size() - base != 64) begin errors++; $display("FAIL rs%0d_count got %0d exp 64", pass, obs.size() - base); end
      while (exp_q.size() > 0) begin
        logic [7:0] e; e = exp_q.pop_front(); checks++;
        if (rd >= obs.size() || obs[rd].b !== e) begin errors++;
          $display("FAIL rs%0d_byte%0d got %h exp %h", pass, rd - base, (rd < obs.size()) ? obs[rd].b : 8'hxx, e); end
        rd++;
      end
    end
  endtask

  task automatic test_reset_mid();
    int n, dn, base;
    base = rd;
    pulse_start();
    n = 0;
    while (n < 3000 && obs.size() - base < 21) begin @(posedge clk); #1; n++; end
    checks++; if (obs.size() - base < 21) begin errors++; $display("FAIL rm_reach got %0d exp 21 bytes", obs.size() - base); end
    rst = 1'b1;
    #1;
    checks++; if (bus.o_TxValid !== 1'b0) begin errors++; $display("FAIL rm_valid got %b exp 0", bus.o_TxValid); end
    checks++; if (bus.o_Busy !== 1'b0) begin errors++; $display("FAIL rm_busy got %b exp 0", bus.o_Busy); end
    dn = 0;
    repeat (3) begin @(posedge clk); #1; if (bus.o_Done) dn++; end
    rst = 1'b0;
    repeat (5) begin @(posedge clk); #1; if (bus.o_Done) dn++; end
    checks++; if (dn != 0) begin errors++; $display("FAIL rm_no_done got %0d exp 0", dn); end
    rd = obs.size();
    base = rd;
    push_dump();
    pulse_start();
    n = 0; dn = 0;
    while (n < 3000 && dn == 0) begin @(posedge clk); #1; n++; if (bus.o_Done) dn = 1; end
    checks++; if (dn == 0) begin errors++; $display("FAIL rm_timeout got no done exp done"); end
    while (exp_q.size() > 0) begin
      logic [7:0] e; e = exp_q.pop_front(); checks++;
      if (rd >= obs.size() || obs[rd].b !== e) begin errors++;
        $display("FAIL rm_byte%0d got %h exp %h", rd - base, (rd < obs.size()) ? obs[rd].b : 8'hxx, e); end
      rd++;
    end
  endtask

  task automatic test_single_cell();
    logic [7:0] got[$];
    int n, dn, maxdir;
    exp_q.push_back(8'h01); exp_q.push_back(8'h02);
    exp_q.push_back(8'h03); exp_q.push_back(8'h04);
    bus1.i_TxReady = 1'b1;
    @(posedge clk); #1 bus1.i_Start = 1'b1;
    @(posedge clk); #1 bus1.i_Start = 1'b0;
    n = 0; dn = 0; maxdir = 0;
    while (n < 200 && dn == 0) begin
      if (bus1.o_TxValid) got.push_back(bus1.o_TxDato);
      if (int'(bus1.o_DebugDireccion) > maxdir) maxdir = int'(bus1.o_DebugDireccion);
      @(posedge clk); #1; n++;
      if (bus1.o_Done) dn = 1;
    end
    checks++; if (dn == 0) begin errors++; $display("FAIL sc_timeout got no done exp done"); end
    checks++; if (maxdir != 0) begin errors++; $display("FAIL sc_maxdir got %0d exp 0", maxdir); end
    checks++; if (got.size() != 4) begin errors++; $display("FAIL sc_count got %0d exp 4", got.size()); end
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic [7:0] e; e = exp_q.pop_front(); checks++;
      if (i >= got.size() || got[i] !== e) begin errors++;
        $display("FAIL sc_byte%0d got %h exp %h", i, (i < got.size()) ? got[i] : 8'hxx, e); end
    end
  endtask

  initial begin
    bus.i_Start = 1'b0;  bus.i_TxReady = 1'b0;
    bus1.i_Start = 1'b0; bus1.i_TxReady = 1'b0;
    for (int i = 0; i < NC; i++) mem[i] = i;
    test_reset();
    test_ascending();
    test_deadbeef();
    test_backpressure();
    test_restart_ignored();
    test_reset_mid();
    test_single_cell();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
